// File: rtl/com_tx_pkg.sv
// Shared definitions for the command-line transmitter: FSM states and the
// minimum hold/gap length that the receive filter needs to see a command.
package com_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } tx_state_e;

  // The receive side debounces over 15 steps, so 16 clocks guarantees pickup and release.
  localparam int MIN_HOLD_CYCLES = 16;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/com_tx_hold_if.sv
// Command request handshake between a command source and com_tx_hold.
interface com_tx_hold_if #(
  parameter int NUM_SIGNALS = 16
);
  logic [NUM_SIGNALS-1:0] com_req;
  logic                   com_valid;
  logic                   com_ready;

  modport master (output com_req, output com_valid, input com_ready);
  modport slave  (input com_req, input com_valid, output com_ready);
endinterface

// File: rtl/com_tx_timer.sv
// Loadable down-counter that parks at zero; zero flag drives the FSM phase ends.
module com_tx_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/com_tx_hold.sv
// Holds each command on active-low lines for HOLD_CYCLES, then idles the lines
// for GAP_CYCLES; one command can wait in a pending slot while another is on air.
module com_tx_hold
  import com_tx_pkg::*;
#(
  parameter int NUM_SIGNALS = 16,
  parameter int HOLD_CYCLES = 20,
  parameter int GAP_CYCLES  = 20
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  com_tx_hold_if.slave           cmd,
  input  logic                   abort,
  output logic [NUM_SIGNALS-1:0] out,
  output logic                   busy,
  output logic                   tx_done
);

  if (HOLD_CYCLES < MIN_HOLD_CYCLES || GAP_CYCLES < MIN_HOLD_CYCLES) begin : g_param_check
    $error("com_tx_hold: HOLD_CYCLES and GAP_CYCLES must be at least %0d", MIN_HOLD_CYCLES);
  end

  localparam int CNT_W = $clog2(max_cycles(HOLD_CYCLES, GAP_CYCLES));
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  tx_state_e              state_q, state_d;
  logic [NUM_SIGNALS-1:0] out_d;
  logic [NUM_SIGNALS-1:0] pend_q, pend_d;
  logic                   pend_empty_q, pend_empty_d;
  logic                   aborted_q, aborted_d;
  logic                   busy_d, done_d;
  logic                   tmr_load, tmr_zero;
  logic [CNT_W-1:0]       tmr_val;
  logic                   take;

  assign cmd.com_ready = pend_empty_q;
  // A zero request is a legal handshake but carries nothing to send.
  assign take = cmd.com_valid && pend_empty_q && !abort && (cmd.com_req != '0);

  com_tx_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .aclr_n   (aclr_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    out_d        = out;
    pend_d       = pend_q;
    pend_empty_d = pend_empty_q;
    aborted_d    = aborted_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state_q)
      IDLE: begin
        if (take) begin
          out_d     = ~cmd.com_req;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LOAD;
          aborted_d = 1'b0;
          state_d   = ASSERT;
        end
      end
      ASSERT: begin
        if (abort) begin
          out_d        = '1;
          pend_empty_d = 1'b1;
          aborted_d    = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = GAP_LOAD;
          state_d      = GAP;
        end else begin
          if (take) begin
            pend_d       = cmd.com_req;
            pend_empty_d = 1'b0;
          end
          if (tmr_zero) begin
            out_d    = '1;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        if (abort) pend_empty_d = 1'b1;
        if (tmr_zero) begin
          done_d = !aborted_q;
          if (!abort && !pend_empty_q) begin
            out_d        = ~pend_q;
            pend_empty_d = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = HOLD_LOAD;
            aborted_d    = 1'b0;
            state_d      = ASSERT;
          end else if (take) begin
            // Arrives on the closing edge of the gap: start it rather than strand it.
            out_d     = ~cmd.com_req;
            tmr_load  = 1'b1;
            tmr_val   = HOLD_LOAD;
            aborted_d = 1'b0;
            state_d   = ASSERT;
          end else begin
            state_d = IDLE;
          end
        end else if (take) begin
          pend_d       = cmd.com_req;
          pend_empty_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q      <= IDLE;
      out          <= '1;
      pend_empty_q <= 1'b1;
      aborted_q    <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state_q      <= state_d;
      out          <= out_d;
      pend_empty_q <= pend_empty_d;
      aborted_q    <= aborted_d;
      busy         <= busy_d;
      tx_done      <= done_d;
    end
  end

  // Pending word is qualified by pend_empty_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule
